jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_ctrl.sv | 116 +++++++++++
 tb/tb_jtag_tap_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM plus IR/DR shift paths and instruction register.
// All state lives in the i_tclk domain; i_trst_n forces Test-Logic-Reset asynchronously.
module jtag_tap_ctrl #(
   parameter int unsigned      REG_W  = 32,
   parameter logic [REG_W-1:0] IDCODE = REG_W'(1)
) (
   input  logic             i_tclk,
   input  logic             i_trst_n,
   input  logic             i_tms,
   input  logic             i_tdi,
   input  logic [REG_W-1:0] i_dataReg,
   output logic             o_tdo,
   output logic [REG_W-1:0] o_shiftReg,
   output logic [REG_W-1:0] o_instrReg,
   output logic             o_stateIsUpdateDr,
   output logic [3:0]       o_state
);

   typedef enum logic [3:0] {
      S_TLR      = 4'd0,
      S_RTI      = 4'd1,
      S_SEL_DR   = 4'd2,
      S_CAP_DR   = 4'd3,
      S_SH_DR    = 4'd4,
      S_EX1_DR   = 4'd5,
      S_PAUSE_DR = 4'd6,
      S_EX2_DR   = 4'd7,
      S_UPD_DR   = 4'd8,
      S_SEL_IR   = 4'd9,
      S_CAP_IR   = 4'd10,
      S_SH_IR    = 4'd11,
      S_EX1_IR   = 4'd12,
      S_PAUSE_IR = 4'd13,
      S_EX2_IR   = 4'd14,
      S_UPD_IR   = 4'd15
   } tap_state_t;

   tap_state_t       r_state;
   tap_state_t       w_next;
   logic [REG_W-1:0] r_dr_shift;
   logic [REG_W-1:0] r_ir_shift;
   logic [REG_W-1:0] r_instr;
   logic             w_tdo;
   logic             w_upd_dr;

   always_ff @(posedge i_tclk or negedge i_trst_n) begin
      if (!i_trst_n) r_state <= S_TLR;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_TLR:      w_next = i_tms ? S_TLR      : S_RTI;
         S_RTI:      w_next = i_tms ? S_SEL_DR   : S_RTI;
         S_SEL_DR:   w_next = i_tms ? S_SEL_IR   : S_CAP_DR;
         S_CAP_DR:   w_next = i_tms ? S_EX1_DR   : S_SH_DR;
         S_SH_DR:    w_next = i_tms ? S_EX1_DR   : S_SH_DR;
         S_EX1_DR:   w_next = i_tms ? S_UPD_DR   : S_PAUSE_DR;
         S_PAUSE_DR: w_next = i_tms ? S_EX2_DR   : S_PAUSE_DR;
         S_EX2_DR:   w_next = i_tms ? S_UPD_DR   : S_SH_DR;
         S_UPD_DR:   w_next = i_tms ? S_SEL_DR   : S_RTI;
         S_SEL_IR:   w_next = i_tms ? S_TLR      : S_CAP_IR;
         S_CAP_IR:   w_next = i_tms ? S_EX1_IR   : S_SH_IR;
         S_SH_IR:    w_next = i_tms ? S_EX1_IR   : S_SH_IR;
         S_EX1_IR:   w_next = i_tms ? S_UPD_IR   : S_PAUSE_IR;
         S_PAUSE_IR: w_next = i_tms ? S_EX2_IR   : S_PAUSE_IR;
         S_EX2_IR:   w_next = i_tms ? S_UPD_IR   : S_SH_IR;
         S_UPD_IR:   w_next = i_tms ? S_SEL_DR   : S_RTI;
         default:    w_next = S_TLR;
      endcase
   end

   // TDO is decoded from registered state only, so it is 0 during reset (state forced to TLR).
   always_comb begin
      w_tdo    = 1'b0;
      w_upd_dr = 1'b0;
      case (r_state)
         S_SH_DR:  w_tdo    = r_dr_shift[0];
         S_SH_IR:  w_tdo    = r_ir_shift[0];
         S_UPD_DR: w_upd_dr = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge i_tclk or negedge i_trst_n) begin
      if (!i_trst_n) begin
         r_dr_shift <= '0;
         r_ir_shift <= '0;
         r_instr    <= IDCODE;
      end else begin
         case (r_state)
            S_CAP_DR: r_dr_shift <= i_dataReg;
            S_SH_DR:  r_dr_shift <= {i_tdi, r_dr_shift[REG_W-1:1]};
            default:  ;
         endcase
         case (r_state)
            S_CAP_IR: r_ir_shift <= REG_W'(1);
            S_SH_IR:  r_ir_shift <= {i_tdi, r_ir_shift[REG_W-1:1]};
            default:  ;
         endcase
         case (r_state)
            S_TLR:    r_instr <= IDCODE;
            S_UPD_IR: r_instr <= r_ir_shift;
            default:  ;
         endcase
      end
   end

   assign o_tdo             = w_tdo;
   assign o_shiftReg        = r_dr_shift;
   assign o_instrReg        = r_instr;
   assign o_stateIsUpdateDr = w_upd_dr;
   assign o_state           = r_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: FSM reachability/reset-by-TMS, IR and DR shifting,
// pause/resume, Update-DR pulse width and asynchronous reset during an IR shift.
module tb_jtag_tap_ctrl;

   localparam int unsigned      REG_W     = 32;
   localparam logic [REG_W-1:0] IDCODE_V  = 32'h0000_0001;
   localparam logic [REG_W-1:0] USER_V    = 32'hA000_0010;
   localparam logic [REG_W-1:0] READ_V    = 32'hDEAD_BEEF;
   localparam logic [REG_W-1:0] UPD_V     = 32'h1234_5678;
   localparam logic [REG_W-1:0] PAUSE_V   = 32'hCAFE_F00D;

   logic             tclk;
   logic             trst_n;
   logic             tms;
   logic             tdi;
   logic [REG_W-1:0] data_reg;
   logic             tdo;
   logic [REG_W-1:0] shift_reg;
   logic [REG_W-1:0] instr_reg;
   logic             upd_dr;
   logic [3:0]       state;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned upd_seen = 0;
   logic        watch_upd = 1'b0;

   // Path from RTI to each state, tms bits applied LSB first.
   logic [7:0]  path_bits [16] = '{8'd7, 8'd0, 8'd1, 8'd1, 8'd1, 8'd5, 8'd5, 8'd21,
                                   8'd13, 8'd3, 8'd3, 8'd3, 8'd11, 8'd11, 8'd43, 8'd27};
   int unsigned path_len  [16] = '{3, 1, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};

   jtag_tap_ctrl #(.REG_W(REG_W), .IDCODE(IDCODE_V)) u_dut (
      .i_tclk           (tclk),
      .i_trst_n         (trst_n),
      .i_tms            (tms),
      .i_tdi            (tdi),
      .i_dataReg        (data_reg),
      .o_tdo            (tdo),
      .o_shiftReg       (shift_reg),
      .o_instrReg       (instr_reg),
      .o_stateIsUpdateDr(upd_dr),
      .o_state          (state)
   );

   initial tclk = 1'b0;
   always #5 tclk = ~tclk;

   always @(posedge tclk) begin
      if (watch_upd && (state == 4'd8 || state == 4'd15)) upd_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive inputs, then advance to 1 time unit after the next rising edge.
   task automatic tick(input logic t_ms, input logic t_di);
      tms = t_ms;
      tdi = t_di;
      @(posedge tclk);
      #1;
   endtask

   initial begin
      logic [REG_W-1:0] stream;
      logic [1:0]       ir_tdo;
      logic [7:0]       bits;

      trst_n   = 1'b0;
      tms      = 1'b1;
      tdi      = 1'b0;
      data_reg = '0;
      #12;
      check("rst_state", 32'(state), 32'd0);
      check("rst_shift", shift_reg, 32'h0);
      check("rst_instr", instr_reg, IDCODE_V);
      check("rst_tdo", 32'(tdo), 32'd0);
      check("rst_upd", 32'(upd_dr), 32'd0);
      trst_n = 1'b1;
      tick(1'b0, 1'b0);
      check("tlr_to_rti", 32'(state), 32'd1);

      for (int s = 0; s < 16; s++) begin
         bits = path_bits[s];
         for (int b = 0; b < int'(path_len[s]); b++) tick(bits[b], 1'b0);
         check($sformatf("reach_%0d", s), 32'(state), 32'(s));
         for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
         check($sformatf("tms5_from_%0d", s), 32'(state), 32'd0);
         tick(1'b0, 1'b0);
      end

      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      check("ir_in_shir", 32'(state), 32'd11);
      for (int i = 0; i < 32; i++) begin
         if (i < 2) ir_tdo[i] = tdo;
         tick(i == 31, USER_V[i]);
      end
      check("ir_tdo_capture", 32'(ir_tdo), 32'd1);
      check("ir_ex1", 32'(state), 32'd12);
      tick(1'b1, 1'b0);
      check("ir_hold_in_updir", instr_reg, IDCODE_V);
      tick(1'b0, 1'b0);
      check("ir_user_loaded", instr_reg, USER_V);

      data_reg = READ_V;
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      check("dr_captured", shift_reg, READ_V);
      for (int i = 0; i < 32; i++) begin
         stream[i] = tdo;
         tick(i == 31, 1'b0);
      end
      check("dr_tdo_stream", stream, READ_V);
      check("dr_drained", shift_reg, 32'h0);
      tick(1'b1, 1'b0); tick(1'b0, 1'b0);
      check("instr_kept", instr_reg, USER_V);

      data_reg = '0;
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) tick(i == 31, UPD_V[i]);
      check("upd_low_ex1", 32'(upd_dr), 32'd0);
      check("upd_shift_val", shift_reg, UPD_V);
      tick(1'b1, 1'b0);
      check("upd_state", 32'(state), 32'd8);
      check("upd_high", 32'(upd_dr), 32'd1);
      check("upd_shift_held", shift_reg, UPD_V);
      tick(1'b0, 1'b0);
      check("upd_low_rti", 32'(upd_dr), 32'd0);

      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) tick(i == 15, PAUSE_V[i]);
      tick(1'b0, 1'b0);
      for (int k = 0; k < 9; k++) tick(1'b0, 1'b1);
      check("pause_state", 32'(state), 32'd6);
      check("pause_held", shift_reg, {PAUSE_V[15:0], 16'h0});
      tick(1'b1, 1'b0);
      check("pause_ex2", 32'(state), 32'd7);
      tick(1'b0, 1'b0);
      for (int i = 16; i < 32; i++) tick(i == 31, PAUSE_V[i]);
      check("pause_resumed", shift_reg, PAUSE_V);
      tick(1'b1, 1'b0); tick(1'b0, 1'b0);

      tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b1);
      watch_upd = 1'b1;
      tms = 1'b1;
      #2;
      trst_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_instr", instr_reg, IDCODE_V);
      check("arst_shift", shift_reg, 32'h0);
      check("arst_tdo", 32'(tdo), 32'd0);
      @(posedge tclk); @(posedge tclk);
      @(negedge tclk);
      trst_n = 1'b1;
      tick(1'b0, 1'b0);
      watch_upd = 1'b0;
      check("arst_no_upd", 32'(upd_seen), 32'd0);
      check("arst_resume", 32'(state), 32'd1);
      check("arst_instr_kept", instr_reg, IDCODE_V);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
